// File: rtl/trace_backpressure_pkg.sv
// trace_bp_pkg: word tags and count-to-payload helper shared by the trace front end
package trace_bp_pkg;
    localparam logic TAG_SAMPLE = 1'b0;
    localparam logic TAG_DROP = 1'b1;
    localparam int MAX_W = 32;
    function automatic logic [MAX_W-1:0] zext_count(input logic [MAX_W-1:0] c, input int w);
        return c & ~({MAX_W{1'b1}} << w);
    endfunction
endpackage

// File: rtl/trace_backpressure_if.sv
// trace_backpressure_if: sample input and trace FIFO handshake bundle
interface trace_backpressure_if #(parameter int sample_width_p = 4);
    logic [sample_width_p-1:0] sample_data;
    logic sample_valid;
    logic [sample_width_p:0] fifo_data;
    logic fifo_valid;
    logic fifo_ready;
    modport slave (input sample_data, sample_valid, fifo_ready, output fifo_data, fifo_valid);
    modport master (output sample_data, sample_valid, fifo_ready, input fifo_data, fifo_valid);
endinterface

// File: rtl/trace_backpressure_sat_drop_counter.sv
// sat_drop_counter: saturating lost-sample counter, clear wins over increment
module sat_drop_counter #(parameter int width_p = 4) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clear_i,
    output logic [width_p-1:0] cnt_o
);
    logic [width_p-1:0] cnt_d, cnt_q;
    always_comb begin
        cnt_d = clear_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/trace_backpressure.sv
// trace_backpressure: lossy sample stage that emits a tagged drop-count word after back-pressure
module trace_backpressure
    import trace_bp_pkg::*;
#(
    parameter int sample_width_p = 4,
    parameter int counter_width_p = 4
) (
    input logic clk,
    input logic rst,
    trace_backpressure_if.slave bus
);
    logic [counter_width_p-1:0] drop_cnt, drop_inc, cnt_sel;
    logic [sample_width_p:0] data_d, data_q;
    logic valid_d, valid_q, can_load, pending, cnt_inc, cnt_clr;
    assign can_load = !valid_q || bus.fifo_ready;
    assign pending = drop_cnt != '0;
    assign drop_inc = &drop_cnt ? drop_cnt : drop_cnt + 1'b1;
    // a sample arriving with the drop word is itself lost, so it joins the count
    assign cnt_sel = bus.sample_valid ? drop_inc : drop_cnt;
    assign cnt_inc = !can_load && bus.sample_valid;
    assign cnt_clr = can_load && pending;
    sat_drop_counter #(.width_p(counter_width_p)) u_cnt (
        .clk(clk),
        .rst(rst),
        .inc_i(cnt_inc),
        .clear_i(cnt_clr),
        .cnt_o(drop_cnt)
    );
    always_comb begin
        valid_d = can_load ? (pending || bus.sample_valid) : valid_q;
        data_d = !can_load ? data_q
               : pending ? {TAG_DROP, sample_width_p'(zext_count(MAX_W'(cnt_sel), counter_width_p))}
               : bus.sample_valid ? {TAG_SAMPLE, bus.sample_data}
               : data_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q <= data_d;
        end
    end
    assign bus.fifo_valid = valid_q;
    assign bus.fifo_data = data_q;
endmodule

// File: tb/tb_trace_backpressure.sv
// tb_trace_backpressure: scoreboard bench with directed plan cases and random back-pressure
module tb_trace_backpressure;
    logic clk = 1'b0;
    logic rst;
    int n_cmp = 0, n_bad = 0;
    logic [4:0] exp_q[$];
    bit m_valid = 0, cur_valid = 0, reset_chk = 0, prev_rst = 1;
    int lost = 0;

    always #5 clk = ~clk;

    trace_backpressure_if #(.sample_width_p(4)) bus ();
    trace_backpressure #(.sample_width_p(4), .counter_width_p(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic cyc(input bit r, input bit sv, input logic [3:0] d, input bit rdy);
        int n;
        @(posedge clk);
        #2;
        reset_chk = prev_rst;
        cur_valid = m_valid;
        rst = r;
        bus.sample_valid = sv;
        bus.sample_data = d;
        bus.fifo_ready = rdy;
        prev_rst = r;
        if (r) begin
            m_valid = 0;
            lost = 0;
            exp_q.delete();
        end else if (m_valid && !rdy) begin
            lost += int'(sv);
        end else if (lost == 0) begin
            if (sv) exp_q.push_back({1'b0, d});
            m_valid = sv;
        end else begin
            n = lost + int'(sv);
            exp_q.push_back({1'b1, 4'(n > 15 ? 15 : n)});
            m_valid = 1;
            lost = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            n_cmp++;
            if (bus.fifo_valid !== cur_valid) begin
                n_bad++;
                $display("FAIL valid: got %b want %b at %0t", bus.fifo_valid, cur_valid, $time);
            end
            if (reset_chk) begin
                n_cmp++;
                if (bus.fifo_data !== 5'h00) begin
                    n_bad++;
                    $display("FAIL reset_data: got %h want 00", bus.fifo_data);
                end
            end
            if (bus.fifo_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL data: got %h want none at %0t", bus.fifo_data, $time);
                end else begin
                    if (bus.fifo_data !== exp_q[0]) begin
                        n_bad++;
                        $display("FAIL data: got %h want %h at %0t", bus.fifo_data, exp_q[0], $time);
                    end
                    if (bus.fifo_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1;
        bus.sample_valid = 0;
        bus.sample_data = 0;
        bus.fifo_ready = 0;
        cyc(1, 1, 5, 1);
        cyc(0, 1, 5, 1);
        cyc(0, 1, 1, 1);
        cyc(0, 1, 2, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 6, 1);
        cyc(0, 1, 7, 0);
        cyc(0, 1, 8, 0);
        cyc(0, 1, 9, 1);
        cyc(0, 1, 10, 1);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 2, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 3, 1);
        for (int i = 0; i < 20; i++) cyc(0, 1, 4'(i), 0);
        cyc(0, 1, 4, 1);
        cyc(0, 1, 6, 1);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 2, 0);
        cyc(0, 1, 3, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 4, 1);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 4'($urandom),
                $urandom_range(0, 9) < ((i / 300) % 2 == 0 ? 7 : 2));
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/trace_backpressure.md
# trace_backpressure

Lossy trace-sample front end between a free-running sample source and a downstream trace FIFO. Valid samples go into a one-word registered output stage with a valid/ready handshake. When the FIFO back-pressures, samples are dropped instead of stalling the source, and the number of lost samples is counted. At the next opportunity a tagged drop-count word is emitted so the trace consumer can see the gap.

## Interface
- sample_width_p, default 4: sample payload width.
- counter_width_p, default 4: drop-counter width. Must satisfy 1 <= counter_width_p <= sample_width_p.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- sample_data  in  sample_width_p  sample payload; ignored when sample_valid=0.
- sample_valid  in  1  sample present this cycle; never back-pressured.
- fifo_data  out  sample_width_p+1  output word: bit [sample_width_p] is the tag, low bits are the payload.
- fifo_valid  out  1  fifo_data holds a word.
- fifo_ready  in  1  FIFO accepts a word this cycle.

## Operation
- Word format:
  - Tag 0 = sample word; payload = sample_data.
  - Tag 1 = drop word; payload = drop count, zero-extended to sample_width_p.
- A transfer occurs on any edge where fifo_valid & fifo_ready.
- can_load = !fifo_valid | fifo_ready. The output register may load a new word on this edge.
- Internal drop_cnt is counter_width_p bits and saturates at 2^counter_width_p-1 (max). A saturated value means "max or more lost".
- Per edge, first matching rule wins:
  1. rst: fifo_valid<=0, fifo_data<=0, drop_cnt<=0.
  2. !can_load:
     - Output register holds.
     - If sample_valid, drop_cnt<=sat(drop_cnt+1).
  3. can_load and drop_cnt==0:
     - If sample_valid, load {0,sample_data} and set fifo_valid<=1.
     - Otherwise fifo_valid<=0. fifo_data need not be held.
  4. can_load and drop_cnt!=0:
     - If sample_valid, load {1, sat(drop_cnt+1)}. The current sample is dropped and is included in the count.
     - Otherwise load {1, drop_cnt}.
     - In both cases fifo_valid<=1 and drop_cnt<=0.
- A drop word is never followed by a further drop word caused by its own emission.

## Timing
- Latency is one cycle: a sample presented at edge N appears on fifo_data after edge N.
- Throughput is one word per cycle while fifo_ready=1.
- fifo_data and fifo_valid are registered, with no combinational path from inputs.
- While fifo_valid=1 and fifo_ready=0, fifo_data and fifo_valid are held stable.
- fifo_ready may change freely while fifo_valid=0.
- Reset values: fifo_valid=0, fifo_data=0, drop_cnt=0.
- Reset mid-operation discards the output word and any pending count.
- Simultaneous accept and new sample on the same edge: the accept frees the stage and the new word loads on that same edge (no bubble).

## Structure
- Package trace_bp_pkg:
  - TAG_SAMPLE=1'b0 and TAG_DROP=1'b1.
  - Helper function for zero-extending the count into the payload.
- Sub-module sat_drop_counter (parameter width_p): inputs inc_i and clear_i, output cnt_o. Saturates at all-ones. clear_i has priority; when both are asserted, the result is 0.
- Top level: output register plus load/priority logic.

## Test plan
- Reset: hold rst for 1 cycle with sample_valid=1 and sample_data=5 -> fifo_valid=0 and fifo_data=0 through the reset edge. The next valid sample 5 appears as 5'h05 one cycle after reset release.
- Streaming: fifo_ready=1, samples 1,2 on consecutive cycles -> fifo_data=5'h01 then 5'h02 with fifo_valid=1. Then sample_valid=0 for 2 cycles -> fifo_valid=0 for those 2 cycles.
- Back-pressure: output holds 5'h06 with fifo_ready=0 while samples 7 and 8 arrive.
  - fifo_data stays 5'h06 with fifo_valid=1.
  - fifo_ready=1 with sample 9 -> next word 5'h13 (3 lost).
  - Then sample 10 -> 5'h0A.
- Idle recovery: drop 2 samples under fifo_ready=0, then fifo_ready=1 with sample_valid=0 -> word 5'h12, then fifo_valid=0.
- Saturation: fifo_ready=0 for 20 cycles of valid samples, then fifo_ready=1 with a valid sample -> word 5'h1F. The following sample is passed unchanged.
- Reset mid-drop: 3 drops pending, assert rst, release, then fifo_ready=1 and sample 4 -> 5'h04 with no drop word.
